// File: rtl/dac_channel_mixer.sv
// dac_channel_mixer: masks and sums N signed channels through a registered
// adder tree, applies a runtime arithmetic shift, saturates to the DAC width,
// counts clipped samples and drives an offset-binary code. A small FSM mutes
// the output at the next zero crossing (or after a timeout) on request.
module dac_channel_mixer #(
    parameter int N_CHANNELS = 5,
    parameter int IW         = 14,
    parameter int OW         = 14,
    parameter int SHW        = 3,
    parameter int ZC_TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [N_CHANNELS*IW-1:0] in_data,
    input  logic [N_CHANNELS-1:0]    ch_enable,
    input  logic [SHW-1:0]           shift,
    input  logic                     mute_req,
    input  logic                     clip_clr,
    output logic [OW-1:0]            out_data,
    output logic                     out_valid,
    output logic                     muted,
    output logic [15:0]              clip_count
);

    localparam int L   = $clog2(N_CHANNELS);
    localparam int SW  = IW + L;                       // full-precision sum width
    localparam int CW  = (SW > OW) ? SW : OW;          // saturation compare width
    localparam int TOW = $clog2(ZC_TIMEOUT + 1);

    localparam logic signed [CW-1:0] SAT_MAX  = CW'((2 ** (OW - 1)) - 1);
    localparam logic signed [CW-1:0] SAT_MIN  = ~SAT_MAX;
    localparam logic [OW-1:0]        MIDSCALE = {1'b1, {(OW-1){1'b0}}};

    typedef enum logic [1:0] {RUN, WAIT_ZC, MUTED} state_t;

    // Nodes present at tree level l (level 0 holds the masked inputs).
    function automatic int nodes_at(input int l);
        return (N_CHANNELS + (1 << l) - 1) >> l;
    endfunction

    // Stage valids: [0] input reg, [1..L] tree, [L+1] saturate, [L+2] output.
    logic [L+2:0]          r_vld_pipe;
    logic [L:0][SHW-1:0]   r_sh_pipe;

    // Advance the valid shift register; cleared asynchronously so in-flight samples die on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_vld_pipe <= '0;
        else        r_vld_pipe <= {r_vld_pipe[L+1:0], in_valid};
    end

    // Carry the shift amount alongside its sample through stage 0 and the tree.
    always_ff @(posedge clk) begin
        r_sh_pipe <= {r_sh_pipe[L-1:0], shift};
    end

    // Adder tree. Samples are sign-extended to the final width at level 0, so
    // every level adds at full precision and no level can overflow. An odd
    // node out at a level is passed straight through.
    for (genvar l = 0; l <= L; l++) begin : g_lvl
        localparam int CNT = nodes_at(l);
        logic [CNT-1:0][SW-1:0] r_node;
        logic [CNT-1:0][SW-1:0] w_node;
        for (genvar k = 0; k < CNT; k++) begin : g_node
            if (l == 0) begin : g_in
                assign w_node[k] = ch_enable[k] ? SW'($signed(in_data[k*IW +: IW])) : '0;
            end else if (2*k + 1 < nodes_at(l - 1)) begin : g_add
                assign w_node[k] = g_lvl[l-1].r_node[2*k] + g_lvl[l-1].r_node[2*k+1];
            end else begin : g_pass
                assign w_node[k] = g_lvl[l-1].r_node[2*k];
            end
        end
        // Register this tree level.
        always_ff @(posedge clk) begin
            r_node <= w_node;
        end
    end

    logic signed [CW-1:0] w_shifted;
    logic [OW-1:0]        w_sat;
    logic                 w_clip;

    assign w_shifted = CW'($signed(g_lvl[L].r_node[0]) >>> r_sh_pipe[L]);

    // Clamp the shifted sum to the signed DAC range and flag any change.
    always_comb begin
        w_sat  = w_shifted[OW-1:0];
        w_clip = 1'b0;
        if (w_shifted > SAT_MAX) begin
            w_sat  = SAT_MAX[OW-1:0];
            w_clip = 1'b1;
        end else if (w_shifted < SAT_MIN) begin
            w_sat  = SAT_MIN[OW-1:0];
            w_clip = 1'b1;
        end
    end

    logic [OW-1:0] r_sat;
    logic          r_clip;

    // Saturation stage register.
    always_ff @(posedge clk) begin
        r_sat  <= w_sat;
        r_clip <= w_clip;
    end

    state_t         r_state;
    logic [TOW-1:0] r_to;
    logic           r_prev_neg;
    logic [OW-1:0]  r_out;
    logic           r_muted;
    logic [15:0]    r_clip_cnt;

    logic           w_zc;
    logic [TOW-1:0] w_to_next;
    logic           w_to_hit;
    logic [OW-1:0]  w_code;

    assign w_zc      = (r_sat == '0) || (r_sat[OW-1] != r_prev_neg);
    assign w_to_next = r_to + TOW'(1);
    assign w_to_hit  = (w_to_next == TOW'(ZC_TIMEOUT));
    assign w_code    = {~r_sat[OW-1], r_sat[OW-2:0]};

    // Mute FSM and output register; the sample that enters MUTED is already midscale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_to       <= '0;
            r_prev_neg <= 1'b0;
            r_out      <= MIDSCALE;
            r_muted    <= 1'b0;
        end else if (r_vld_pipe[L+1]) begin
            r_prev_neg <= r_sat[OW-1];
            r_out      <= w_code;
            r_muted    <= 1'b0;
            case (r_state)
                RUN: begin
                    if (mute_req) begin
                        r_state <= WAIT_ZC;
                        r_to    <= '0;
                    end
                end
                WAIT_ZC: begin
                    if (!mute_req) begin
                        r_state <= RUN;
                    end else if (w_zc || w_to_hit) begin
                        r_state <= MUTED;
                        r_out   <= MIDSCALE;
                        r_muted <= 1'b1;
                    end else begin
                        r_to <= w_to_next;
                    end
                end
                MUTED: begin
                    if (!mute_req) begin
                        r_state <= RUN;
                    end else begin
                        r_out   <= MIDSCALE;
                        r_muted <= 1'b1;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

    // Saturating clip counter; a clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_clip_cnt <= '0;
        else if (clip_clr)
            r_clip_cnt <= '0;
        else if (r_vld_pipe[L+1] && r_clip && (r_clip_cnt != 16'hFFFF))
            r_clip_cnt <= r_clip_cnt + 16'd1;
    end

    assign out_data   = r_out;
    assign out_valid  = r_vld_pipe[L+2];
    assign muted      = r_muted;
    assign clip_count = r_clip_cnt;

endmodule

// File: tb/tb_dac_channel_mixer.sv
// Scoreboard bench for dac_channel_mixer: the driver pushes the expected
// saturated value per sample, the monitor pops it on out_valid and applies a
// reference mute/clip model before comparing.
module tb_dac_channel_mixer;

    localparam int NCH = 5;
    localparam int IW  = 14;
    localparam int OW  = 14;
    localparam int SHW = 3;
    localparam int ZCT = 1024;
    localparam int MID = 8192;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              in_valid = 1'b0;
    logic [NCH*IW-1:0] in_data = '0;
    logic [NCH-1:0]    ch_enable = '0;
    logic [SHW-1:0]    shift = '0;
    logic              mute_req = 1'b0;
    logic              clip_clr = 1'b0;
    logic [OW-1:0]     out_data;
    logic              out_valid;
    logic              muted;
    logic [15:0]       clip_count;

    dac_channel_mixer #(
        .N_CHANNELS(NCH), .IW(IW), .OW(OW), .SHW(SHW), .ZC_TIMEOUT(ZCT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .ch_enable(ch_enable), .shift(shift), .mute_req(mute_req),
        .clip_clr(clip_clr), .out_data(out_data), .out_valid(out_valid),
        .muted(muted), .clip_count(clip_count)
    );

    always #5 clk = ~clk;

    typedef struct { int val; bit clip; int cyc; } exp_t;
    typedef enum int { M_RUN, M_WZC, M_MUTED } mst_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   smp[NCH];
    mst_t m_st = M_RUN;
    int   m_to = 0;
    bit   m_prev = 1'b0;
    int   m_cnt = 0;
    bit   seen_muted = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Monitor: one step per clock edge, 1 time unit after it.
    always @(posedge clk) begin
        exp_t e;
        int   eo;
        bit   em;
        bit   neg;
        bit   popped;
        #1;
        cyc++;
        popped = 1'b0;
        if (!rst_n) begin
            sb.delete();
            m_st = M_RUN; m_to = 0; m_prev = 1'b0; m_cnt = 0;
        end else begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_out_valid", out_valid, 0);
                end else begin
                    e = sb.pop_front();
                    popped = 1'b1;
                    // sampling edge is cyc_in+1, output appears L+2 = 5 edges later
                    chk("latency", cyc - e.cyc, 6);
                    neg = (e.val < 0);
                    eo  = e.val + MID;
                    case (m_st)
                        M_RUN: if (mute_req) begin m_st = M_WZC; m_to = 0; end
                        M_WZC: begin
                            if (!mute_req) m_st = M_RUN;
                            else begin
                                m_to++;
                                if (e.val == 0 || neg != m_prev || m_to == ZCT) begin
                                    m_st = M_MUTED;
                                    eo   = MID;
                                end
                            end
                        end
                        default: begin
                            if (!mute_req) m_st = M_RUN;
                            else eo = MID;
                        end
                    endcase
                    m_prev = neg;
                    em = (m_st == M_MUTED);
                    if (em) seen_muted = 1'b1;
                    chk("out_data", out_data, eo);
                    chk("muted", muted, em);
                end
            end
            if (clip_clr) m_cnt = 0;
            else if (popped && e.clip && m_cnt != 65535) m_cnt++;
            if (out_valid) chk("clip_count", clip_count, m_cnt);
        end
    end

    task automatic send(input logic [NCH-1:0] m, input int sh);
        int sum;
        int v;
        exp_t e;
        logic [IW-1:0] t;
        @(negedge clk);
        sum = 0;
        for (int i = 0; i < NCH; i++) begin
            t = smp[i][IW-1:0];
            in_data[i*IW +: IW] = t;
            if (m[i]) sum += smp[i];
        end
        ch_enable = m;
        shift     = sh[SHW-1:0];
        in_valid  = 1'b1;
        v = sum >>> sh;
        e.clip = (v > 8191) || (v < -8192);
        e.val  = (v > 8191) ? 8191 : (v < -8192) ? -8192 : v;
        e.cyc  = cyc;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 50) begin
            @(posedge clk);
            t++;
        end
        #2;
        chk("drain", sb.size(), 0);
    endtask

    task automatic expect_out(input string tag, input int exp);
        int t = 0;
        while (t < 20) begin
            @(posedge clk);
            #2;
            t++;
            if (out_valid) break;
        end
        if (out_valid) chk(tag, out_data, exp);
        else           chk({tag, "_timeout"}, out_valid, 1);
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < NCH; i++) smp[i] = v;
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        // asynchronous reset before any clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_data", out_data, MID);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_muted", muted, 0);
        chk("rst_clip_count", clip_count, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // basic sum, saturation, shift, mask
        fill(1000);
        send(5'b11111, 0); idle(1);
        expect_out("sum_1000", 13192);
        chk("clip_after_1000", clip_count, 0);

        fill(8191);
        send(5'b11111, 0); idle(1);
        expect_out("sat_pos", 16383);
        chk("clip_after_sat", clip_count, 1);
        send(5'b11111, 3); idle(1);
        expect_out("shift3", 13311);
        chk("clip_after_shift3", clip_count, 1);

        smp[0] = -4096;
        send(5'b00001, 0); idle(1);
        expect_out("mask_ch0", 4096);

        fill(-8192);
        send(5'b11111, 0); idle(1);
        expect_out("sat_neg", 0);

        // back-to-back stream with mask/shift changing every sample
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < NCH; i++) smp[i] = $urandom_range(0, 16383) - 8192;
            send(5'($urandom), $urandom_range(0, 7));
        end
        idle(1); drain();

        @(negedge clk) clip_clr = 1'b1;
        @(negedge clk) clip_clr = 1'b0;
        chk("clip_clr_idle", clip_count, 0);

        // sine on ch0, mute requested then released mid-stream
        for (int k = 0; k < 220; k++) begin
            smp[0] = $rtoi(3000.0 * $sin(6.283185307 * real'(k) / 37.0));
            for (int i = 1; i < NCH; i++) smp[i] = $urandom_range(0, 16383) - 8192;
            mute_req = (k >= 50 && k < 160);
            send(5'b00001, 0);
        end
        idle(1); drain();
        chk("sine_mute_seen", seen_muted, 1);
        chk("sine_unmuted", muted, 0);

        // DC input never crosses zero: mute comes from the timeout
        fill(0); smp[0] = 100;
        mute_req = 1'b0;
        for (int k = 0; k < 20; k++) send(5'b00001, 0);
        mute_req = 1'b1;
        for (int k = 0; k < 1100; k++) send(5'b00001, 0);
        idle(1); drain();
        chk("dc_timeout_muted", muted, 1);
        mute_req = 1'b0;
        send(5'b00001, 0); idle(1);
        expect_out("dc_unmute", 8292);
        chk("dc_unmute_flag", muted, 0);

        // reset in the middle of a stream
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < NCH; i++) smp[i] = $urandom_range(0, 16383) - 8192;
            send(5'b11111, $urandom_range(0, 7));
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data", out_data, MID);
        chk("midrst_muted", muted, 0);
        chk("midrst_clip_count", clip_count, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("post_rst_quiet", out_valid, 0);
        fill(1000);
        send(5'b11111, 0); idle(1);
        expect_out("post_rst_first", 13192);

        // clip counter saturation and clear priority
        fill(8191);
        for (int k = 0; k < 65543; k++) send(5'b11111, 0);
        @(posedge clk);
        #2;
        chk("clip_hold", clip_count, 16'hFFFF);
        send(5'b11111, 0);
        clip_clr = 1'b1;
        @(posedge clk);
        #2;
        chk("clr_priority", clip_count, 0);
        chk("clr_with_valid", out_valid, 1);
        send(5'b11111, 0);
        clip_clr = 1'b0;
        repeat (3) send(5'b11111, 0);
        idle(1); drain();
        chk("clip_recount", clip_count, 9);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/dac_channel_mixer.md
DAC_CHANNEL_MIXER -- requirements
Module: dac_channel_mixer

Interface
REQ-001 SHALL have parameter N_CHANNELS, default 5: number of summed channels, range 2..16.
REQ-002 SHALL have parameter IW, default 14: signed per-channel sample width.
REQ-003 SHALL have parameter OW, default 14: DAC output width, offset-binary.
REQ-004 SHALL have parameter SHW, default 3: width of the runtime right-shift control.
REQ-005 SHALL have parameter ZC_TIMEOUT, default 1024: valid samples to wait for a zero crossing before a forced mute.
REQ-006 SHALL have port clk, input, 1: sole clock; all state in this domain.
REQ-007 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port in_valid, input, 1: in_data holds one sample per channel this cycle.
REQ-009 SHALL have port in_data, input, N_CHANNELS*IW: packed signed samples, channel i at bits [i*IW +: IW].
REQ-010 SHALL have port ch_enable, input, N_CHANNELS: per-channel include mask, sampled with in_valid.
REQ-011 SHALL have port shift, input, SHW: arithmetic right shift applied to the sum, sampled with in_valid.
REQ-012 SHALL have port mute_req, input, 1: level request to mute the output.
REQ-013 SHALL have port clip_clr, input, 1: synchronous clear of clip_count.
REQ-014 SHALL have port out_data, output, OW: offset-binary DAC code.
REQ-015 SHALL have port out_valid, output, 1: out_data updated this cycle (DAC write strobe).
REQ-016 SHALL have port muted, output, 1: high while the mute FSM is in MUTED.
REQ-017 SHALL have port clip_count, output, 16: number of saturated output samples.

Function
REQ-018 SHALL register the inputs in stage 0, replacing a disabled channel's sample with 0.
REQ-019 SHALL sum the channels in a registered binary adder tree of L = clog2(N_CHANNELS) levels, full precision IW+L bits, sign-extending at each level.
REQ-020 SHALL right-shift the sum arithmetically by shift (0..2^SHW-1), then saturate it to the signed OW range [-2^(OW-1), 2^(OW-1)-1], registered as one stage.
REQ-021 SHALL convert the saturated value to offset binary (value + 2^(OW-1), i.e. invert the MSB) in a final output register.
REQ-022 SHALL assert out_valid exactly L+2 cycles after in_valid, one pulse per input pulse, with no throughput loss for back-to-back in_valid.
REQ-023 SHALL propagate ch_enable and shift with the sample they were sampled with; mid-stream changes SHALL NOT affect samples already in flight.
REQ-024 SHALL flag a sample as clipped when saturation changed its value.
REQ-025 SHALL increment clip_count once per valid clipped sample, holding at 0xFFFF; clip_clr SHALL set it to 0 and SHALL take priority over a simultaneous increment.
REQ-026 SHALL implement a mute FSM with states RUN, WAIT_ZC and MUTED, evaluated on valid post-saturation samples.
REQ-027 SHALL move from RUN to WAIT_ZC when mute_req=1; the timeout counter SHALL start at 0.
REQ-028 SHALL move from WAIT_ZC to MUTED on the first valid sample that is 0, or whose sign differs from the previous valid sample, or when the timeout count reaches ZC_TIMEOUT.
REQ-029 SHALL return from WAIT_ZC to RUN when mute_req=0.
REQ-030 SHALL return from MUTED to RUN when mute_req=0; the first sample after leaving MUTED SHALL pass unmuted.
REQ-031 SHALL output midscale 2^(OW-1) for the sample that triggers the entry into MUTED and for every sample while in MUTED; out_valid and clip counting SHALL continue unchanged while muted.
REQ-032 SHALL assert muted in the same cycle that the first midscale sample is presented.

Reset
REQ-033 SHALL, while rst_n=0, immediately force: out_data = 2^(OW-1), out_valid = 0, muted = 0, clip_count = 0, all pipeline valids = 0, FSM = RUN, timeout counter = 0, previous-sign register = 0.
REQ-034 SHALL discard in-flight samples when reset is asserted mid-stream, and SHALL produce out_valid only for in_valid seen after reset release.

Verification (N_CHANNELS=5, IW=14, OW=14, SHW=3, latency 5)
REQ-035 SHALL be checked with all channels +1000, mask 11111, shift 0, one in_valid -> out_valid exactly 5 cycles later, out_data=13192, clip_count=0.
REQ-036 SHALL be checked with all channels +8191, shift 0 -> out_data=16383, clip_count=1; then shift 3 -> out_data=13311, no increment.
REQ-037 SHALL be checked with mask 00001, ch0=-4096, others +8191 -> out_data=4096; a mask change with samples in flight affects only later samples.
REQ-038 SHALL be checked with a continuous sine, then mute_req=1 -> midscale 8192 and muted=1 from the first sign change; with DC +100 instead -> muted after 1024 valid samples; mute_req=0 -> the next sample is unmuted.
REQ-039 SHALL be checked by pulling rst_n low mid-stream -> out_valid=0 and out_data=8192 without waiting for a clk edge, and no stale out_valid after release.
REQ-040 SHALL be checked with clip_count=0xFFFF plus a further clip -> it holds at 0xFFFF; clip_clr together with a clipped sample -> clip_count=0.
